// File: rtl/fp_exp_normalize_pkg.sv
// fp_exp_normalize_pkg: shared widths, constants and result flags for the normaliser
package fp_exp_normalize_pkg;
  localparam int SP_EXP_W = 8;
  localparam int SP_MAN_W = 23;
  localparam int DP_EXP_W = 11;
  localparam int DP_MAN_W = 52;
  localparam logic [31:0] EXP_ALL_ONES = '1;
  typedef struct packed {
    logic ovf;
    logic unf;
    logic zero;
  } res_flags_t;
endpackage

// File: rtl/fp_lzc.sv
// fp_lzc: leading-zero counter, returns W for an all-zero input
module fp_lzc #(
  parameter int W  = 24,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  din_i,
  output logic [CW-1:0] cnt_o
);
  // scan upward so the most significant set bit has the final say
  always_comb begin
    cnt_o = CW'(W);
    for (int i = 0; i < W; i++) cnt_o = din_i[i] ? CW'(W - 1 - i) : cnt_o;
  end
endmodule

// File: rtl/fp_exp_normalize.sv
// fp_exp_normalize: two-stage normaliser handling carry, leading zeros, overflow and underflow
module fp_exp_normalize
  import fp_exp_normalize_pkg::*;
#(
  parameter int EXP_W = SP_EXP_W,
  parameter int MAN_W = SP_MAN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [MAN_W+1:0] in_man,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [EXP_W-1:0] out_exp,
  output logic [MAN_W-1:0] out_man,
  output logic             out_ovf,
  output logic             out_unf,
  output logic             out_zero
);
  localparam int LW = $clog2(MAN_W + 2);
  localparam int SW = EXP_W + 2;
  localparam logic [EXP_W-1:0] ALL1 = EXP_ALL_ONES[EXP_W-1:0];
  localparam logic signed [SW-1:0] E_MAX = $signed({2'b00, ALL1});
  logic             s1_v_q, s1_sign_q, s1_carry_q, s1_zero_q, s1_spec_q;
  logic [EXP_W-1:0] s1_exp_q;
  logic [MAN_W:0]   s1_man_q;
  logic [LW-1:0]    s1_lzc_q, lzc;
  logic             s2_v_q, s2_sign_q;
  logic [EXP_W-1:0] s2_exp_q, s2_exp_d;
  logic [MAN_W-1:0] s2_man_q, s2_man_d, m;
  res_flags_t       s2_flg_q, s2_flg_d;
  logic             s1_adv, s2_adv, ovf, unf;
  logic signed [SW-1:0] e;
  assign s2_adv   = !s2_v_q || out_ready;
  assign s1_adv   = !s1_v_q || s2_adv;
  assign in_ready = s1_adv;
  fp_lzc #(.W(MAN_W + 1), .CW(LW)) u_lzc (
    .din_i(in_man[MAN_W:0]),
    .cnt_o(lzc)
  );
  // stage 1: capture the beat with its carry, leading-zero count and classification
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q     <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_exp_q   <= '0;
      s1_man_q   <= '0;
      s1_carry_q <= 1'b0;
      s1_lzc_q   <= '0;
      s1_zero_q  <= 1'b0;
      s1_spec_q  <= 1'b0;
    end else if (s1_adv) begin
      s1_v_q <= in_valid;
      if (in_valid) begin
        s1_sign_q  <= in_sign;
        s1_exp_q   <= in_exp;
        s1_man_q   <= in_man[MAN_W:0];
        s1_carry_q <= in_man[MAN_W+1];
        s1_lzc_q   <= lzc;
        s1_zero_q  <= in_man == '0;
        s1_spec_q  <= in_exp == ALL1;
      end
    end
  end
  // stage 2 datapath: widened signed exponent so saturation is detected before any wrap
  always_comb begin
    e = s1_carry_q ? $signed({2'b00, s1_exp_q}) + SW'(1)
                   : $signed({2'b00, s1_exp_q}) - $signed({{(SW-LW){1'b0}}, s1_lzc_q});
    m = s1_carry_q ? s1_man_q[MAN_W:1] : s1_man_q[MAN_W-1:0] << s1_lzc_q;
    ovf = e >= E_MAX;
    unf = e[SW-1] || e == '0;
    s2_flg_d.ovf  = !s1_spec_q && !s1_zero_q && ovf;
    s2_flg_d.unf  = !s1_spec_q && !s1_zero_q && !ovf && unf;
    s2_flg_d.zero = !s1_spec_q && s1_zero_q;
    s2_exp_d = s1_spec_q ? s1_exp_q : s1_zero_q ? '0 : ovf ? ALL1 : unf ? '0 : e[EXP_W-1:0];
    s2_man_d = s1_spec_q ? s1_man_q[MAN_W-1:0] : (s1_zero_q || ovf || unf) ? '0 : m;
  end
  // stage 2: output register, held while downstream stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v_q    <= 1'b0;
      s2_sign_q <= 1'b0;
      s2_exp_q  <= '0;
      s2_man_q  <= '0;
      s2_flg_q  <= '0;
    end else if (s2_adv) begin
      s2_v_q <= s1_v_q;
      if (s1_v_q) begin
        s2_sign_q <= s1_sign_q;
        s2_exp_q  <= s2_exp_d;
        s2_man_q  <= s2_man_d;
        s2_flg_q  <= s2_flg_d;
      end
    end
  end
  assign out_valid = s2_v_q;
  assign out_sign  = s2_sign_q;
  assign out_exp   = s2_exp_q;
  assign out_man   = s2_man_q;
  assign out_ovf   = s2_flg_q.ovf;
  assign out_unf   = s2_flg_q.unf;
  assign out_zero  = s2_flg_q.zero;
endmodule

// File: tb/tb_fp_exp_normalize.sv
// tb_fp_exp_normalize: scoreboard bench for the two-stage normaliser
module tb_fp_exp_normalize;
  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
    logic        ovf;
    logic        unf;
    logic        zero;
  } res_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0, in_ready, in_sign = 1'b0;
  logic [7:0]  in_exp = '0;
  logic [24:0] in_man = '0;
  logic        out_valid, out_ready = 1'b1, out_sign;
  logic [7:0]  out_exp;
  logic [22:0] out_man;
  logic        out_ovf, out_unf, out_zero;
  res_t        obs, held;
  logic        stalled = 1'b0;
  res_t        q[$];
  int          n_cmp = 0, n_bad = 0;
  logic [7:0]  bp_e[4];
  logic [24:0] bp_m[4];
  fp_exp_normalize #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign), .in_exp(in_exp), .in_man(in_man),
    .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign), .out_exp(out_exp),
    .out_man(out_man), .out_ovf(out_ovf), .out_unf(out_unf), .out_zero(out_zero)
  );
  always #5 clk = ~clk;
  assign obs = {out_sign, out_exp, out_man, out_ovf, out_unf, out_zero};
  task automatic chk(string tag, logic [63:0] got, logic [63:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask
  function automatic res_t r(logic s, logic [7:0] e, logic [22:0] m, logic [2:0] f);
    return {s, e, m, f};
  endfunction
  // reference: normalise by explicit shifting until the hidden bit is set
  function automatic res_t model(logic s, logic [7:0] e, logic [24:0] m);
    res_t x;
    int ee;
    logic [24:0] mm;
    x = '0;
    x.sign = s;
    if (e == 8'hFF) begin
      x.exp = e;
      x.man = m[22:0];
      return x;
    end
    if (m == '0) begin
      x.zero = 1'b1;
      return x;
    end
    ee = int'(e);
    mm = m;
    if (mm[24]) begin
      ee++;
      mm = mm >> 1;
    end else begin
      while (!mm[23]) begin
        mm = mm << 1;
        ee--;
      end
    end
    if (ee >= 255) begin
      x.exp = 8'hFF;
      x.ovf = 1'b1;
    end else if (ee <= 0) x.unf = 1'b1;
    else begin
      x.exp = ee[7:0];
      x.man = mm[22:0];
    end
    return x;
  endfunction
  task automatic send(logic s, logic [7:0] e, logic [24:0] m, res_t x);
    int k = 0;
    in_valid = 1'b1;
    in_sign  = s;
    in_exp   = e;
    in_man   = m;
    #1;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("accept", in_ready, 1);
    q.push_back(x);
    @(negedge clk);
    in_valid = 1'b0;
  endtask
  task automatic drain();
    int k = 0;
    while (q.size() != 0 && k < 30) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    chk("drain", q.size(), 0);
  endtask
  // output monitor: pops the scoreboard on each transfer and checks stability under stall
  always @(negedge clk) begin
    #1;
    if (!rst_n) stalled = 1'b0;
    else begin
      if (stalled && out_valid) chk("hold", obs, held);
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("spurious", out_valid, 0);
        else chk("beat", obs, q.pop_front());
      end
      stalled = out_valid && !out_ready;
      held = obs;
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end
  initial begin
    int nxt;
    logic s;
    logic [7:0] e;
    logic [24:0] m;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", obs, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", in_ready, 1);
    @(negedge clk);
    send(0, 8'h7F, 25'h1000000, r(0, 8'h80, 23'h0, 3'b000));
    #1;
    chk("lat_early", out_valid, 0);
    @(negedge clk);
    #1;
    chk("lat_two", out_valid, 1);
    @(negedge clk);
    send(1, 8'h85, 25'h0200000, r(1, 8'h83, 23'h0, 3'b000));
    send(0, 8'h85, 25'h0300000, r(0, 8'h83, 23'h400000, 3'b000));
    send(0, 8'hFE, 25'h1800000, r(0, 8'hFF, 23'h0, 3'b100));
    send(1, 8'h02, 25'h0000100, r(1, 8'h00, 23'h0, 3'b010));
    send(0, 8'h55, 25'h0000000, r(0, 8'h00, 23'h0, 3'b001));
    send(1, 8'hFF, 25'h0400001, r(1, 8'hFF, 23'h400001, 3'b000));
    send(0, 8'h00, 25'h1000000, r(0, 8'h01, 23'h0, 3'b000));
    send(0, 8'h40, 25'h0ABCDEF, r(0, 8'h40, 23'h2BCDEF, 3'b000));
    send(0, 8'h03, 25'h0200000, r(0, 8'h01, 23'h0, 3'b000));
    send(0, 8'h02, 25'h0200000, r(0, 8'h00, 23'h0, 3'b010));
    send(0, 8'hFD, 25'h1000000, r(0, 8'hFE, 23'h0, 3'b000));
    send(0, 8'h30, 25'h0000001, r(0, 8'h19, 23'h0, 3'b000));
    send(1, 8'hFF, 25'h0000000, r(1, 8'hFF, 23'h0, 3'b000));
    send(0, 8'h00, 25'h0800000, r(0, 8'h00, 23'h0, 3'b010));
    send(0, 8'h10, 25'h1FFFFFF, r(0, 8'h11, 23'h7FFFFF, 3'b000));
    for (int i = 0; i < 24; i++) begin
      s = 1'(($urandom) & 1);
      e = 8'($urandom_range(0, 255));
      m = 25'($urandom) >> $urandom_range(0, 24);
      send(s, e, m, model(s, e, m));
    end
    drain();
    bp_e[0] = 8'h20; bp_m[0] = 25'h1234567;
    bp_e[1] = 8'h21; bp_m[1] = 25'h0012345;
    bp_e[2] = 8'h22; bp_m[2] = 25'h0876543;
    bp_e[3] = 8'h23; bp_m[3] = 25'h0000777;
    nxt = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      in_valid = nxt < 4;
      if (nxt < 4) begin
        in_sign = 1'(nxt & 1);
        in_exp  = bp_e[nxt];
        in_man  = bp_m[nxt];
      end
      #1;
      if (in_valid && in_ready) begin
        q.push_back(model(in_sign, in_exp, in_man));
        nxt++;
      end
      @(negedge clk);
    end
    #1;
    chk("bp_accepted", nxt, 2);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    @(negedge clk);
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      in_valid = nxt < 4;
      if (nxt < 4) begin
        in_sign = 1'(nxt & 1);
        in_exp  = bp_e[nxt];
        in_man  = bp_m[nxt];
      end
      #1;
      chk("bp_stream", out_valid, 1);
      if (in_valid && in_ready) begin
        q.push_back(model(in_sign, in_exp, in_man));
        nxt++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("bp_all_sent", nxt, 4);
    drain();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_sign = 1'b0;
    in_exp = 8'h40;
    in_man = 25'h0800000;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("mid_full", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", obs, 0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("post_rst_valid", out_valid, 0);
      chk("post_rst_ready", in_ready, 1);
      @(negedge clk);
    end
    send(1, 8'h7E, 25'h0400000, r(1, 8'h7D, 23'h0, 3'b000));
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fp_exp_normalize.md
Name: fp_exp_normalize

Overview:
- Parametrised, pipelined normalisation stage for the floating-point datapath.
- Successor to the single-purpose exponent-increment logic. Takes a raw post-add/post-multiply sign, exponent and mantissa, and handles three cases:
  - carry-out: right shift by 1, exponent +1;
  - leading zeros: left shift by LZC, exponent −LZC;
  - exponent overflow/underflow: saturate/flush.
- Two-stage pipeline with valid/ready handshake. Sits between the mantissa adder/multiplier and result packing.

Parameters:
- EXP_W, 8, exponent width (8 = single, 11 = double).
- MAN_W, 23, stored fraction width (hidden bit excluded).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  stage can accept a beat this cycle.
- in_sign  input  1  sign, passed through.
- in_exp  input  EXP_W  biased exponent before normalisation.
- in_man  input  MAN_W+2  bit MAN_W+1 = carry, bit MAN_W = hidden, low MAN_W = fraction.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_sign  output  1  sign.
- out_exp  output  EXP_W  normalised biased exponent.
- out_man  output  MAN_W  normalised fraction (hidden bit dropped).
- out_ovf  output  1  overflow: result forced to infinity.
- out_unf  output  1  underflow: result flushed to zero.
- out_zero  output  1  exact zero mantissa input.

Behaviour:
- Reset (rst_n low, asynchronous):
  - both stage valid flags cleared;
  - all output data and flags driven 0;
  - in_ready = 1 after release.
  - Reset mid-operation discards in-flight beats; no partial output.
- Handshake:
  - s2_adv = !s2_v || out_ready;
  - s1_adv = !s1_v || s2_adv;
  - in_ready = s1_adv.
  - A beat transfers when valid && ready on that port.
  - Outputs hold stable while out_valid && !out_ready.
  - Latency exactly 2 cycles when unstalled; throughput 1 beat/cycle.
  - Order preserved; no beat is dropped or duplicated.
- Stage 1 (registered):
  - capture sign, exp, man;
  - compute carry = in_man[MAN_W+1];
  - compute lzc = count of leading zeros in in_man[MAN_W:0], range 0..MAN_W+1;
  - compute is_zero = (in_man == 0) and special = (in_exp == all ones).
- Stage 2 (registered to outputs), priority order:
  1. special: pass exp and fraction unchanged; no flags.
  2. is_zero: exp = 0, man = 0, out_zero = 1.
  3. carry: e = exp+1; man = in_man[MAN_W:1]. Truncation only, no rounding.
  4. otherwise: e = exp − lzc; man = (in_man << lzc)[MAN_W-1:0].
- Exponent arithmetic uses EXP_W+2-bit signed intermediates; no wrap-around is permitted.
- After cases 3/4:
  - if e ≥ 2^EXP_W−1: exp = all ones, man = 0, out_ovf = 1;
  - else if e ≤ 0: exp = 0, man = 0, out_unf = 1 (no denormals);
  - else exp = e[EXP_W-1:0].
- At most one of out_ovf / out_unf / out_zero is high per beat.
- Flags qualify only when out_valid is high.
- Boundary cases:
  - in_exp = 0 with nonzero mantissa is processed arithmetically; the carry case yields exp 1.
  - lzc = 0 with no carry leaves exp and fraction unchanged.

Decomposition:
- Shared package: EXP_W/MAN_W defaults for single/double, EXP_ALL_ONES constant, and a packed result-flag struct {ovf, unf, zero}.
- One natural sub-module: fp_lzc (parametrised leading-zero counter, width MAN_W+1, output $clog2(MAN_W+2) bits), instantiated in stage 1.

Test Plan (EXP_W=8, MAN_W=23):
- Carry case: exp 0x7F, man 25'h1000000 → two cycles later exp 0x80, man 0, all flags 0.
- Left normalise: exp 0x85, man 25'h0200000 (lzc 2) → exp 0x83, man 0. Also exp 0x85, man 25'h0300000 → exp 0x83, man 23'h400000.
- Overflow: exp 0xFE, man 25'h1800000 → exp 0xFF, man 0, out_ovf = 1.
- Underflow and zero:
  - exp 0x02, man 25'h0000100 (lzc 15) → exp 0, man 0, out_unf = 1;
  - man 0 → exp 0, out_zero = 1;
  - exp 0xFF, man 25'h0400001 → passthrough exp 0xFF, man 23'h400001.
- Backpressure: out_ready low for 6 cycles while 4 beats are offered → exactly 2 accepted, then in_ready = 0. Outputs stay stable. After release, all 4 beats emerge in order, one per cycle.
- Reset mid-stream: assert rst_n low with both stages full → out_valid = 0 immediately (asynchronous). After release, no stale beat emerges and in_ready = 1.
